// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the iterative restoring divider.
//   div_state_t    : divider FSM state encoding (IDLE, CALC, DONE)
//   DIV_MAX_WIDTH  : widest operand the divider supports
//   div_cnt_width  : bit width needed for a counter that holds 0..max_count
// Optional feature macro used by the divider: DIV_ABORT_EN.
// -----------------------------------------------------------------------------
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_MAX_WIDTH = 8;

   // Width of a down-counter that must be able to hold the value max_count.
   function automatic int div_cnt_width(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/borrow_look_ahead_subtractor.sv
// -----------------------------------------------------------------------------
// borrow_look_ahead_subtractor
// Combinational subtractor diff = a - b - borrow_in using borrow lookahead.
// Every internal borrow is a flat sum of products of generate/propagate
// terms, so no borrow ripples through a neighbouring bit's borrow.
// Parameters:
//   DATA_WIDTH : operand width, 1 to 9
// Ports:
//   a_in       : minuend
//   b_in       : subtrahend
//   borrow_in  : borrow into bit 0
//   diff_out   : difference
//   borrow_out : borrow out of the MSB (1 means a < b + borrow_in)
// -----------------------------------------------------------------------------
module borrow_look_ahead_subtractor #(
   parameter int DATA_WIDTH = 9
) (
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   input  logic                  borrow_in,
   output logic [DATA_WIDTH-1:0] diff_out,
   output logic                  borrow_out
);

   // gen: bit produces a borrow on its own (a=0, b=1)
   // prop: bit passes an incoming borrow through (a == b)
   logic [DATA_WIDTH-1:0] gen_s;
   logic [DATA_WIDTH-1:0] prop_s;
   logic [DATA_WIDTH:0]   borrow_s;

   assign gen_s  = ~a_in & b_in;
   assign prop_s = ~(a_in ^ b_in);

   // Borrow out of bit idx: a generate at any bit j<=idx propagated through
   // bits j+1..idx, or borrow_in propagated through bits 0..idx.
   function automatic logic lookahead_borrow(
      input int                    idx,
      input logic [DATA_WIDTH-1:0] g,
      input logic [DATA_WIDTH-1:0] p,
      input logic                  bin
   );
      logic acc;
      logic prod;
      acc = 1'b0;
      for (int j = 0; j <= idx; j++) begin
         prod = g[j];
         for (int k = j + 1; k <= idx; k++) begin
            prod = prod & p[k];
         end
         acc = acc | prod;
      end
      prod = bin;
      for (int k = 0; k <= idx; k++) begin
         prod = prod & p[k];
      end
      return acc | prod;
   endfunction

   assign borrow_s[0] = borrow_in;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_borrow
      assign borrow_s[i+1] = lookahead_borrow(i, gen_s, prop_s, borrow_in);
   end

   assign diff_out   = a_in ^ b_in ^ borrow_s[DATA_WIDTH-1:0];
   assign borrow_out = borrow_s[DATA_WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
// Iterative unsigned restoring divider, one quotient bit per clock.
// A divide with a nonzero divisor takes DATA_WIDTH iterations after the
// accept edge; a zero divisor spends one cycle in CALC and then reports
// quotient all-ones, remainder = dividend and div_by_zero_out=1.
// Parameters:
//   DATA_WIDTH      : operand width, 1 to 8
// Ports:
//   clk_in          : clock, rising edge
//   rst_in          : synchronous active-high reset
//   start_in        : request, accepted only while ready_out=1
//   dividend_in     : dividend, sampled on the accept edge
//   divisor_in      : divisor, sampled on the accept edge
//   abort_in        : cancel an operation in CALC (only with DIV_ABORT_EN)
//   ready_out       : high in IDLE
//   valid_out       : one-cycle pulse in DONE, results freshly registered
//   quotient_out    : quotient, held until the next valid_out
//   remainder_out   : remainder, held until the next valid_out
//   div_by_zero_out : divisor was zero, held with the result
// Optional feature macro: DIV_ABORT_EN (adds abort_in).
// -----------------------------------------------------------------------------
module restoring_divider
   import div_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   input  logic [DATA_WIDTH-1:0] dividend_in,
   input  logic [DATA_WIDTH-1:0] divisor_in,
`ifdef DIV_ABORT_EN
   input  logic                  abort_in,
`endif
   output logic                  ready_out,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] quotient_out,
   output logic [DATA_WIDTH-1:0] remainder_out,
   output logic                  div_by_zero_out
);

   localparam int RW    = DATA_WIDTH + 1;           // partial remainder width
   localparam int CNT_W = div_cnt_width(DATA_WIDTH);

   div_state_t             state_q,     state_d;
   logic [RW-1:0]          rem_q,       rem_d;
   logic [DATA_WIDTH-1:0]  quo_q,       quo_d;
   logic [DATA_WIDTH-1:0]  dvs_q,       dvs_d;
   logic [CNT_W-1:0]       cnt_q,       cnt_d;
   logic                   dbz_pend_q,  dbz_pend_d;
   logic [DATA_WIDTH-1:0]  quotient_q,  quotient_d;
   logic [DATA_WIDTH-1:0]  remainder_q, remainder_d;
   logic                   dbz_q,       dbz_d;

   logic [RW+DATA_WIDTH-1:0] rq_shift_s;
   logic [RW-1:0]            r_shift_s;
   logic [DATA_WIDTH-1:0]    q_shift_s;
   logic [RW-1:0]            trial_diff_s;
   logic                     trial_borrow_s;
   logic [RW-1:0]            rem_next_s;
   logic [DATA_WIDTH-1:0]    quo_next_s;
   logic                     abort_s;

`ifdef DIV_ABORT_EN
   assign abort_s = abort_in;
`else
   assign abort_s = 1'b0;
`endif

   // {R,Q} move left as one register pair: Q's MSB enters R's LSB.
   assign rq_shift_s = {rem_q, quo_q} << 1;
   assign r_shift_s  = rq_shift_s[RW+DATA_WIDTH-1:DATA_WIDTH];
   assign q_shift_s  = rq_shift_s[DATA_WIDTH-1:0];

   borrow_look_ahead_subtractor #(
      .DATA_WIDTH (RW)
   ) u_trial_sub (
      .a_in       (r_shift_s),
      .b_in       ({1'b0, dvs_q}),
      .borrow_in  (1'b0),
      .diff_out   (trial_diff_s),
      .borrow_out (trial_borrow_s)
   );

   // Restore on borrow: keep the shifted remainder and emit a 0 quotient bit.
   always_comb begin
      rem_next_s    = trial_borrow_s ? r_shift_s : trial_diff_s;
      quo_next_s    = q_shift_s;
      quo_next_s[0] = ~trial_borrow_s;
   end

   // Next-state and datapath control for IDLE/CALC/DONE.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      dbz_pend_d  = dbz_pend_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         IDLE: begin
            if (start_in) begin
               quo_d   = dividend_in;
               rem_d   = '0;
               dvs_d   = divisor_in;
               state_d = CALC;
               // A zero divisor still spends one cycle in CALC so its
               // result appears one edge after the accept edge.
               if (divisor_in == '0) begin
                  dbz_pend_d = 1'b1;
                  cnt_d      = CNT_W'(1);
               end else begin
                  dbz_pend_d = 1'b0;
                  cnt_d      = CNT_W'(DATA_WIDTH);
               end
            end else begin
               state_d = IDLE;
            end
         end

         CALC: begin
            if (abort_s) begin
               state_d = IDLE;
            end else if (dbz_pend_q) begin
               state_d     = DONE;
               quotient_d  = '1;
               remainder_d = quo_q;
               dbz_d       = 1'b1;
            end else begin
               rem_d = rem_next_s;
               quo_d = quo_next_s;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d     = DONE;
                  quotient_d  = quo_next_s;
                  // R < D after the last step, so the top bit is zero.
                  remainder_d = rem_next_s[DATA_WIDTH-1:0];
                  dbz_d       = 1'b0;
               end else begin
                  state_d = CALC;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, working and result registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         dbz_pend_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         dbz_pend_q  <= dbz_pend_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign ready_out       = (state_q == IDLE);
   assign valid_out       = (state_q == DONE);
   assign quotient_out    = quotient_q;
   assign remainder_out   = remainder_q;
   assign div_by_zero_out = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider
// Directed table of divides with hand-computed results and latencies, plus
// hand-written sequences for back-to-back starts, reset mid-operation,
// abort (when DIV_ABORT_EN is defined) and a random sweep against a / and %
// reference. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_restoring_divider;

   localparam int DW = 8;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          start_in;
   logic [DW-1:0] dividend_in;
   logic [DW-1:0] divisor_in;
`ifdef DIV_ABORT_EN
   logic          abort_in;
`endif
   logic          ready_out;
   logic          valid_out;
   logic [DW-1:0] quotient_out;
   logic [DW-1:0] remainder_out;
   logic          div_by_zero_out;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] dvd;
      logic [7:0] dvs;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
      int         lat;
   } vec_t;

   vec_t vecs[12];

   always #5 clk_in = ~clk_in;

   restoring_divider #(.DATA_WIDTH(DW)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .start_in        (start_in),
      .dividend_in     (dividend_in),
      .divisor_in      (divisor_in),
`ifdef DIV_ABORT_EN
      .abort_in        (abort_in),
`endif
      .ready_out       (ready_out),
      .valid_out       (valid_out),
      .quotient_out    (quotient_out),
      .remainder_out   (remainder_out),
      .div_by_zero_out (div_by_zero_out)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   // Counts edges from the accept edge until valid_out, bounded.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!valid_out && lat < 40) begin
         @(negedge clk_in);
         lat++;
      end
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int lat;
      @(negedge clk_in);
      check({tag, "_ready_before"}, int'(ready_out), 1);
      dividend_in = v.dvd;
      divisor_in  = v.dvs;
      start_in    = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      start_in = 1'b0;
      check({tag, "_ready_busy"}, int'(ready_out), 0);
      wait_valid(lat);
      check({tag, "_latency"},   lat, v.lat);
      check({tag, "_quotient"},  int'(quotient_out), int'(v.q));
      check({tag, "_remainder"}, int'(remainder_out), int'(v.r));
      check({tag, "_dbz"},       int'(div_by_zero_out), int'(v.dbz));
      @(negedge clk_in);
      check({tag, "_valid_pulse"}, int'(valid_out), 0);
      check({tag, "_ready_after"}, int'(ready_out), 1);
      check({tag, "_quotient_hold"}, int'(quotient_out), int'(v.q));
   endtask

   initial begin
      int   lat;
      bit   saw_valid;
      vec_t rv;

      vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 8};
      vecs[1]  = '{8'd77,  8'd0,   8'd255, 8'd77, 1'b1, 1};
      vecs[2]  = '{8'd9,   8'd3,   8'd3,   8'd0,  1'b0, 8};
      vecs[3]  = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8};
      vecs[4]  = '{8'd5,   8'd255, 8'd0,   8'd5,  1'b0, 8};
      vecs[5]  = '{8'd100, 8'd9,   8'd11,  8'd1,  1'b0, 8};
      vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 8};
      vecs[7]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8};
      vecs[8]  = '{8'd1,   8'd2,   8'd0,   8'd1,  1'b0, 8};
      vecs[9]  = '{8'd254, 8'd16,  8'd15,  8'd14, 1'b0, 8};
      vecs[10] = '{8'd0,   8'd0,   8'd255, 8'd0,  1'b1, 1};
      vecs[11] = '{8'd128, 8'd3,   8'd42,  8'd2,  1'b0, 8};

      rst_in      = 1'b1;
      start_in    = 1'b0;
      dividend_in = '0;
      divisor_in  = '0;
`ifdef DIV_ABORT_EN
      abort_in    = 1'b0;
`endif

      // Reset state
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      check("reset_ready",     int'(ready_out), 1);
      check("reset_valid",     int'(valid_out), 0);
      check("reset_quotient",  int'(quotient_out), 0);
      check("reset_remainder", int'(remainder_out), 0);
      check("reset_dbz",       int'(div_by_zero_out), 0);
      rst_in = 1'b0;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-to-back with start held high: 255/1 then 5/255
      @(negedge clk_in);
      dividend_in = 8'd255;
      divisor_in  = 8'd1;
      start_in    = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      dividend_in = 8'd5;
      divisor_in  = 8'd255;
      wait_valid(lat);
      check("b2b_first_latency",   lat, 8);
      check("b2b_first_quotient",  int'(quotient_out), 255);
      check("b2b_first_remainder", int'(remainder_out), 0);
      @(negedge clk_in);
      check("b2b_ready_gap", int'(ready_out), 1);
      check("b2b_valid_gap", int'(valid_out), 0);
      @(posedge clk_in);
      @(negedge clk_in);
      start_in = 1'b0;
      check("b2b_second_busy", int'(ready_out), 0);
      wait_valid(lat);
      check("b2b_second_latency",   lat, 8);
      check("b2b_second_quotient",  int'(quotient_out), 0);
      check("b2b_second_remainder", int'(remainder_out), 5);

      // Reset at edge 4 of a 100/9 operation
      @(negedge clk_in);
      dividend_in = 8'd100;
      divisor_in  = 8'd9;
      start_in    = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      start_in = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;
      check("midrst_ready",     int'(ready_out), 1);
      check("midrst_quotient",  int'(quotient_out), 0);
      check("midrst_remainder", int'(remainder_out), 0);
      saw_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk_in);
         if (valid_out) saw_valid = 1'b1;
      end
      check("midrst_no_valid", int'(saw_valid), 0);
      run_op('{8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 8}, "after_rst");

`ifdef DIV_ABORT_EN
      // Abort at edge 3 of 50/6 keeps the previous 28/4 result
      run_op(vecs[0], "pre_abort");
      @(negedge clk_in);
      dividend_in = 8'd50;
      divisor_in  = 8'd6;
      start_in    = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      start_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      check("abort_busy", int'(ready_out), 0);
      abort_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      abort_in = 1'b0;
      check("abort_ready", int'(ready_out), 1);
      saw_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk_in);
         if (valid_out) saw_valid = 1'b1;
      end
      check("abort_no_valid",  int'(saw_valid), 0);
      check("abort_quotient",  int'(quotient_out), 28);
      check("abort_remainder", int'(remainder_out), 4);
      check("abort_dbz",       int'(div_by_zero_out), 0);
`endif

      // Random sweep against the language's / and %
      for (int n = 0; n < 40; n++) begin
         rv.dvd = 8'($urandom_range(0, 255));
         rv.dvs = 8'($urandom_range(1, 255));
         rv.q   = rv.dvd / rv.dvs;
         rv.r   = rv.dvd % rv.dvs;
         rv.dbz = 1'b0;
         rv.lat = 8;
         run_op(rv, $sformatf("rnd%0d", n));
         check($sformatf("rnd%0d_identity", n),
               int'(quotient_out) * int'(rv.dvs) + int'(remainder_out),
               int'(rv.dvd));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
